// File: rtl/cart_map_pkg.sv
// Shared definitions for the cartridge mapper arbiter: channel indices,
// default turbo-block mask, idle bus levels and the arbiter state type.
package cart_map_pkg;

    // Mapper channel indices (channel 0 is the default LoROM/HiROM/DSP mapper)
    localparam int CH_DLH     = 0;
    localparam int CH_CX4     = 1;
    localparam int CH_SDD1    = 2;
    localparam int CH_GSU     = 3;
    localparam int CH_SA1     = 4;
    localparam int CH_SPC7110 = 5;

    // Bit i set means channel i+1 forbids CPU turbo (SDD1 and SA1)
    localparam logic [4:0] TURBO_BLOCK_DEF = 5'b01010;

    // Levels driven onto the shared bus while no mapper owns it
    localparam logic       STROBE_IDLE_N = 1'b1;
    localparam logic       LEVEL_IDLE    = 1'b0;
    localparam logic [7:0] DATA_IDLE     = 8'h00;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cart_map_arbiter_if.sv
// Bundle of per-channel mapper inputs and the shared cartridge bus outputs.
// The arbiter uses the slave view; the surrounding top level uses master.
interface cart_map_arbiter_if #(
    parameter int NUM_MAP = 5,
    parameter int ROM_AW  = 24,
    parameter int RAM_AW  = 20
);
    localparam int NCH   = NUM_MAP + 1;
    localparam int SEL_W = $clog2(NCH);

    // Mapper side
    logic [NUM_MAP-1:0]    MAP_ACTIVE;
    logic [8*NCH-1:0]      M_DO;
    logic [NCH-1:0]        M_IRQ_N;
    logic [ROM_AW*NCH-1:0] M_ROM_ADDR;
    logic [NCH-1:0]        M_ROM_CE_N;
    logic [NCH-1:0]        M_ROM_OE_N;
    logic [NCH-1:0]        M_ROM_WORD;
    logic [RAM_AW*NCH-1:0] M_BSRAM_ADDR;
    logic [8*NCH-1:0]      M_BSRAM_D;
    logic [NCH-1:0]        M_BSRAM_CE_N;
    logic [NCH-1:0]        M_BSRAM_OE_N;
    logic [NCH-1:0]        M_BSRAM_WE_N;

    // Shared bus and status side
    logic [7:0]        DI;
    logic              IRQ_N;
    logic [ROM_AW-1:0] ROM_ADDR;
    logic              ROM_CE_N;
    logic              ROM_OE_N;
    logic              ROM_WORD;
    logic [RAM_AW-1:0] BSRAM_ADDR;
    logic [7:0]        BSRAM_D;
    logic              BSRAM_CE_N;
    logic              BSRAM_OE_N;
    logic              BSRAM_WE_N;
    logic [SEL_W-1:0]  SEL;
    logic [NCH-1:0]    CH_ACTIVE;
    logic              TURBO_ALLOW;
    logic              MAP_ERR;
    logic              SWITCHING;

    modport slave (
        input  MAP_ACTIVE, M_DO, M_IRQ_N, M_ROM_ADDR, M_ROM_CE_N, M_ROM_OE_N,
               M_ROM_WORD, M_BSRAM_ADDR, M_BSRAM_D, M_BSRAM_CE_N, M_BSRAM_OE_N,
               M_BSRAM_WE_N,
        output DI, IRQ_N, ROM_ADDR, ROM_CE_N, ROM_OE_N, ROM_WORD, BSRAM_ADDR,
               BSRAM_D, BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N, SEL, CH_ACTIVE,
               TURBO_ALLOW, MAP_ERR, SWITCHING
    );

    modport master (
        output MAP_ACTIVE, M_DO, M_IRQ_N, M_ROM_ADDR, M_ROM_CE_N, M_ROM_OE_N,
               M_ROM_WORD, M_BSRAM_ADDR, M_BSRAM_D, M_BSRAM_CE_N, M_BSRAM_OE_N,
               M_BSRAM_WE_N,
        input  DI, IRQ_N, ROM_ADDR, ROM_CE_N, ROM_OE_N, ROM_WORD, BSRAM_ADDR,
               BSRAM_D, BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N, SEL, CH_ACTIVE,
               TURBO_ALLOW, MAP_ERR, SWITCHING
    );

endinterface

// File: rtl/cart_map_onehot_dec.sv
// Decodes a one-hot active-flag vector into a channel index (bit i -> i+1).
// Zero or several flags set give index 0; several set also raise multi_hot_o.
module cart_map_onehot_dec #(
    parameter int N = 5
) (
    input  logic [N-1:0]             map_active_i,
    output logic [$clog2(N+1)-1:0]   target_o,
    output logic                     multi_hot_o
);
    localparam int TW = $clog2(N + 1);

    logic          seen;
    logic          multi;
    logic [TW-1:0] idx;

    // Scan the flags, remembering the last set bit and whether a second one appeared
    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (map_active_i[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
                idx  = TW'(i + 1);
            end
        end
        target_o    = (seen && !multi) ? idx : '0;
        multi_hot_o = multi;
    end

endmodule

// File: rtl/cart_map_arbiter.sv
// Cartridge mapper output arbiter: registers the selected mapper channel,
// idles the shared bus for DRAIN_CYC cycles while the selection changes,
// and flags illegal multi-hot MAP_ACTIVE until reset.
module cart_map_arbiter
    import cart_map_pkg::*;
#(
    parameter int                   NUM_MAP     = 5,
    parameter int                   ROM_AW      = 24,
    parameter int                   RAM_AW      = 20,
    parameter int                   DRAIN_CYC   = 4,
    parameter logic [NUM_MAP-1:0]   TURBO_BLOCK = NUM_MAP'(TURBO_BLOCK_DEF)
) (
    input  logic              MCLK,
    input  logic              RESET,
    cart_map_arbiter_if.slave map
);
    localparam int NCH   = NUM_MAP + 1;
    localparam int SEL_W = $clog2(NCH);
    localparam int CNT_W = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

    // Reload value for the drain counter; counts down to 0 inclusive
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
    // Turbo block per channel index; channel 0 never blocks
    localparam logic [NCH-1:0]   BLOCK_BY_CH = {TURBO_BLOCK, 1'b0};

    logic [SEL_W-1:0] target;
    logic             multi_hot;

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             idle;

    cart_map_onehot_dec #(
        .N (NUM_MAP)
    ) u_dec (
        .map_active_i (map.MAP_ACTIVE),
        .target_o     (target),
        .multi_hot_o  (multi_hot)
    );

    // Selection/drain state registers with synchronous reset
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
            sel_q   <= SEL_W'(CH_DLH);
            pend_q  <= SEL_W'(CH_DLH);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: hold, start/restart/abort a drain, or commit the pending channel
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        err_d   = err_q | multi_hot;
        unique case (state_q)
            ST_RUN: begin
                if (target != sel_q) begin
                    if (DRAIN_CYC > 0) begin
                        state_d = ST_DRAIN;
                        pend_d  = target;
                        cnt_d   = CNT_RELOAD;
                    end else begin
                        sel_d   = target;
                    end
                end
            end
            ST_DRAIN: begin
                if (target == sel_q) begin
                    state_d = ST_RUN;
                end else if (target != pend_q) begin
                    pend_d  = target;
                    cnt_d   = CNT_RELOAD;
                end else if (cnt_q == '0) begin
                    sel_d   = pend_q;
                    state_d = ST_RUN;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output mux: zero-latency pass-through of the selected channel, idle while draining or in reset
    always_comb begin
        idle            = RESET || (state_q == ST_DRAIN);
        map.DI          = DATA_IDLE;
        map.IRQ_N       = STROBE_IDLE_N;
        map.ROM_ADDR    = '0;
        map.ROM_CE_N    = STROBE_IDLE_N;
        map.ROM_OE_N    = STROBE_IDLE_N;
        map.ROM_WORD    = LEVEL_IDLE;
        map.BSRAM_ADDR  = '0;
        map.BSRAM_D     = DATA_IDLE;
        map.BSRAM_CE_N  = STROBE_IDLE_N;
        map.BSRAM_OE_N  = STROBE_IDLE_N;
        map.BSRAM_WE_N  = STROBE_IDLE_N;
        map.CH_ACTIVE   = '0;
        if (!idle) begin
            map.DI          = map.M_DO[sel_q*8 +: 8];
            map.IRQ_N       = map.M_IRQ_N[sel_q];
            map.ROM_ADDR    = map.M_ROM_ADDR[sel_q*ROM_AW +: ROM_AW];
            map.ROM_CE_N    = map.M_ROM_CE_N[sel_q];
            map.ROM_OE_N    = map.M_ROM_OE_N[sel_q];
            map.ROM_WORD    = map.M_ROM_WORD[sel_q];
            map.BSRAM_ADDR  = map.M_BSRAM_ADDR[sel_q*RAM_AW +: RAM_AW];
            map.BSRAM_D     = map.M_BSRAM_D[sel_q*8 +: 8];
            map.BSRAM_CE_N  = map.M_BSRAM_CE_N[sel_q];
            map.BSRAM_OE_N  = map.M_BSRAM_OE_N[sel_q];
            map.BSRAM_WE_N  = map.M_BSRAM_WE_N[sel_q];
            map.CH_ACTIVE   = NCH'(1) << sel_q;
        end
        map.SEL         = sel_q;
        map.TURBO_ALLOW = ~BLOCK_BY_CH[sel_q];
        map.MAP_ERR     = err_q;
        map.SWITCHING   = (state_q == ST_DRAIN);
    end

endmodule

// File: tb/tb_cart_map_arbiter.sv
// Bench for cart_map_arbiter: directed scenarios followed by random traffic,
// all outputs compared every cycle against a behavioural selection model.
module tb_cart_map_arbiter;
    localparam int NUM_MAP   = 5;
    localparam int ROM_AW    = 24;
    localparam int RAM_AW    = 20;
    localparam int DRAIN_CYC = 4;
    localparam int NCH       = NUM_MAP + 1;
    localparam logic [NUM_MAP-1:0] TB_BLOCK = 5'b01010;

    logic MCLK = 1'b0;
    logic RESET;

    always #5 MCLK = ~MCLK;

    cart_map_arbiter_if #(.NUM_MAP(NUM_MAP), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) bus ();

    cart_map_arbiter #(
        .NUM_MAP   (NUM_MAP),
        .ROM_AW    (ROM_AW),
        .RAM_AW    (RAM_AW),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .MCLK  (MCLK),
        .RESET (RESET),
        .map   (bus)
    );

    // Per-channel stimulus held as plain arrays
    logic [7:0]        ch_do       [NCH];
    logic              ch_irq_n    [NCH];
    logic [ROM_AW-1:0] ch_rom_addr [NCH];
    logic              ch_rom_ce_n [NCH];
    logic              ch_rom_oe_n [NCH];
    logic              ch_rom_word [NCH];
    logic [RAM_AW-1:0] ch_ram_addr [NCH];
    logic [7:0]        ch_ram_d    [NCH];
    logic              ch_ram_ce_n [NCH];
    logic              ch_ram_oe_n [NCH];
    logic              ch_ram_we_n [NCH];

    // Reference model: selected channel, pending channel (-1 = none), drain cycles left
    int m_sel, m_pend, m_left;
    bit m_err;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic pack_bus();
        for (int k = 0; k < NCH; k++) begin
            bus.M_DO[8*k +: 8]                 = ch_do[k];
            bus.M_IRQ_N[k]                     = ch_irq_n[k];
            bus.M_ROM_ADDR[ROM_AW*k +: ROM_AW] = ch_rom_addr[k];
            bus.M_ROM_CE_N[k]                  = ch_rom_ce_n[k];
            bus.M_ROM_OE_N[k]                  = ch_rom_oe_n[k];
            bus.M_ROM_WORD[k]                  = ch_rom_word[k];
            bus.M_BSRAM_ADDR[RAM_AW*k +: RAM_AW] = ch_ram_addr[k];
            bus.M_BSRAM_D[8*k +: 8]            = ch_ram_d[k];
            bus.M_BSRAM_CE_N[k]                = ch_ram_ce_n[k];
            bus.M_BSRAM_OE_N[k]                = ch_ram_oe_n[k];
            bus.M_BSRAM_WE_N[k]                = ch_ram_we_n[k];
        end
    endtask

    task automatic rand_ch();
        for (int k = 0; k < NCH; k++) begin
            ch_do[k]       = 8'($urandom);
            ch_irq_n[k]    = 1'($urandom);
            ch_rom_addr[k] = ROM_AW'($urandom);
            ch_rom_ce_n[k] = 1'($urandom);
            ch_rom_oe_n[k] = 1'($urandom);
            ch_rom_word[k] = 1'($urandom);
            ch_ram_addr[k] = RAM_AW'($urandom);
            ch_ram_d[k]    = 8'($urandom);
            ch_ram_ce_n[k] = 1'($urandom);
            ch_ram_oe_n[k] = 1'($urandom);
            ch_ram_we_n[k] = 1'($urandom);
        end
        pack_bus();
    endtask

    function automatic int target_of(input logic [NUM_MAP-1:0] m);
        if ($countones(m) != 1) return 0;
        for (int i = 0; i < NUM_MAP; i++)
            if (m[i]) return i + 1;
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_edge();
        int t;
        if (RESET) begin
            m_sel = 0; m_pend = -1; m_left = 0; m_err = 1'b0;
        end else begin
            t = target_of(bus.MAP_ACTIVE);
            if ($countones(bus.MAP_ACTIVE) > 1) m_err = 1'b1;
            if (m_pend < 0) begin
                if (t != m_sel) begin
                    if (DRAIN_CYC == 0) m_sel = t;
                    else begin m_pend = t; m_left = DRAIN_CYC; end
                end
            end else if (t == m_sel) begin
                m_pend = -1;
            end else if (t != m_pend) begin
                m_pend = t; m_left = DRAIN_CYC;
            end else begin
                m_left--;
                if (m_left == 0) begin m_sel = m_pend; m_pend = -1; end
            end
        end
    endtask

    task automatic check_all();
        bit idle;
        bit [NCH-1:0] act;
        idle = RESET || (m_pend >= 0);
        act  = idle ? '0 : (NCH'(1) << m_sel);
        chk_val("SEL",       64'(bus.SEL),         64'(m_sel));
        chk_val("SWITCHING", 64'(bus.SWITCHING),   64'(m_pend >= 0));
        chk_val("MAP_ERR",   64'(bus.MAP_ERR),     64'(m_err));
        chk_val("TURBO",     64'(bus.TURBO_ALLOW), 64'((m_sel == 0) ? 1'b1 : !TB_BLOCK[m_sel-1]));
        chk_val("CH_ACTIVE", 64'(bus.CH_ACTIVE),   64'(act));
        chk_val("DI",        64'(bus.DI),          idle ? 64'd0 : 64'(ch_do[m_sel]));
        chk_val("IRQ_N",     64'(bus.IRQ_N),       idle ? 64'd1 : 64'(ch_irq_n[m_sel]));
        chk_val("ROM_ADDR",  64'(bus.ROM_ADDR),    idle ? 64'd0 : 64'(ch_rom_addr[m_sel]));
        chk_val("ROM_CE_N",  64'(bus.ROM_CE_N),    idle ? 64'd1 : 64'(ch_rom_ce_n[m_sel]));
        chk_val("ROM_OE_N",  64'(bus.ROM_OE_N),    idle ? 64'd1 : 64'(ch_rom_oe_n[m_sel]));
        chk_val("ROM_WORD",  64'(bus.ROM_WORD),    idle ? 64'd0 : 64'(ch_rom_word[m_sel]));
        chk_val("BSRAM_ADDR",64'(bus.BSRAM_ADDR),  idle ? 64'd0 : 64'(ch_ram_addr[m_sel]));
        chk_val("BSRAM_D",   64'(bus.BSRAM_D),     idle ? 64'd0 : 64'(ch_ram_d[m_sel]));
        chk_val("BSRAM_CE_N",64'(bus.BSRAM_CE_N),  idle ? 64'd1 : 64'(ch_ram_ce_n[m_sel]));
        chk_val("BSRAM_OE_N",64'(bus.BSRAM_OE_N),  idle ? 64'd1 : 64'(ch_ram_oe_n[m_sel]));
        chk_val("BSRAM_WE_N",64'(bus.BSRAM_WE_N),  idle ? 64'd1 : 64'(ch_ram_we_n[m_sel]));
    endtask

    task automatic step();
        @(posedge MCLK);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int r, v;
        m_sel = 0; m_pend = -1; m_left = 0; m_err = 1'b0;
        RESET = 1'b1;
        bus.MAP_ACTIVE = '0;
        rand_ch();
        ch_rom_addr[0] = 24'h008000;
        pack_bus();

        // Reset, then channel 0 passes through
        step(); step();
        chk_val("rst_rom_idle", 64'(bus.ROM_ADDR), 64'd0);
        chk_val("rst_ch_act",   64'(bus.CH_ACTIVE), 64'd0);
        RESET = 1'b0;
        step();
        chk_val("rst_sel",   64'(bus.SEL),         64'd0);
        chk_val("rst_rom",   64'(bus.ROM_ADDR),    64'h008000);
        chk_val("rst_err",   64'(bus.MAP_ERR),     64'd0);
        chk_val("rst_turbo", 64'(bus.TURBO_ALLOW), 64'd1);
        chk_val("rst_act",   64'(bus.CH_ACTIVE),   64'd1);

        // Switch to channel 3: four idle cycles then channel 3
        bus.MAP_ACTIVE = 5'b00100;
        for (int i = 0; i < DRAIN_CYC; i++) begin
            rand_ch();
            step();
            chk_val("drn_sw",  64'(bus.SWITCHING), 64'd1);
            chk_val("drn_rce", 64'(bus.ROM_CE_N),  64'd1);
            chk_val("drn_bce", 64'(bus.BSRAM_CE_N),64'd1);
        end
        rand_ch();
        step();
        chk_val("sw3_sel", 64'(bus.SEL),       64'd3);
        chk_val("sw3_sw",  64'(bus.SWITCHING), 64'd0);
        chk_val("sw3_rom", 64'(bus.ROM_ADDR),  64'(ch_rom_addr[3]));

        // Channel 4 blocks turbo, channel 1 allows it
        bus.MAP_ACTIVE = 5'b01000;
        for (int i = 0; i <= DRAIN_CYC; i++) begin rand_ch(); step(); end
        chk_val("t4_sel",   64'(bus.SEL),         64'd4);
        chk_val("t4_turbo", 64'(bus.TURBO_ALLOW), 64'd0);
        bus.MAP_ACTIVE = 5'b00001;
        for (int i = 0; i <= DRAIN_CYC; i++) begin rand_ch(); step(); end
        chk_val("t1_sel",   64'(bus.SEL),         64'd1);
        chk_val("t1_turbo", 64'(bus.TURBO_ALLOW), 64'd1);

        // Multi-hot sets a sticky error that only reset clears
        bus.MAP_ACTIVE = 5'b00011;
        rand_ch(); step();
        chk_val("mh_err", 64'(bus.MAP_ERR), 64'd1);
        bus.MAP_ACTIVE = '0;
        for (int i = 0; i < 6; i++) begin rand_ch(); step(); end
        chk_val("mh_sticky", 64'(bus.MAP_ERR), 64'd1);
        chk_val("mh_sel",    64'(bus.SEL),     64'd0);
        RESET = 1'b1; step();
        RESET = 1'b0; step();
        chk_val("mh_clr", 64'(bus.MAP_ERR), 64'd0);

        // Drain aborted on drain cycle 2
        bus.MAP_ACTIVE = 5'b00001;
        rand_ch(); step();
        rand_ch(); step();
        bus.MAP_ACTIVE = '0;
        rand_ch(); step();
        chk_val("ab_sel", 64'(bus.SEL),       64'd0);
        chk_val("ab_sw",  64'(bus.SWITCHING), 64'd0);
        chk_val("ab_rce", 64'(bus.ROM_CE_N),  64'(ch_rom_ce_n[0]));

        // Reset during drain toward channel 5
        bus.MAP_ACTIVE = 5'b10000;
        rand_ch(); step();
        RESET = 1'b1;
        rand_ch(); step();
        chk_val("rd_sel", 64'(bus.SEL),       64'd0);
        chk_val("rd_sw",  64'(bus.SWITCHING), 64'd0);
        chk_val("rd_rce", 64'(bus.ROM_CE_N),  64'd1);
        RESET = 1'b0;
        bus.MAP_ACTIVE = '0;
        rand_ch(); step();
        chk_val("rd_rom", 64'(bus.ROM_ADDR), 64'(ch_rom_addr[0]));

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rand_ch();
            r = $urandom_range(0, 99);
            if (r >= 70 && r < 92) begin
                v = $urandom_range(0, NUM_MAP);
                bus.MAP_ACTIVE = (v == 0) ? '0 : NUM_MAP'(1 << (v - 1));
            end else if (r >= 92 && r < 95) begin
                bus.MAP_ACTIVE = NUM_MAP'($urandom);
            end
            RESET = ($urandom_range(0, 99) < 2);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
